mont_mult_param: RTL and testbench
==================================

MONT_MULT_PARAM -- requirements
Module: mont_mult_param

Interface
REQ-001 Parameter WIDTH, default 32: operand/modulus width in bits.
REQ-002 Parameter LEN_W, default 8: width of the len port; SHALL satisfy 2^LEN_W > WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 len  input  LEN_W  iteration count n (R = 2^n), valid 1..WIDTH.
REQ-007 num_1, num_2  input  WIDTH each  multiplicands, required < modulus.
REQ-008 modulus  input  WIDTH  odd modulus M.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when mm_out is valid.
REQ-011 err  output  1  qualifies done; high when the request was rejected.
REQ-012 mm_out  output  WIDTH  result num_1*num_2*R^-1 mod M; held until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, ITER, FINAL, with no other reachable states.
REQ-014 IDLE with start=1: latch len, num_1, num_2, modulus; clear the accumulator and bit index; set busy=1; go to ITER.
REQ-015 Request check at the accepting edge: if len==0, len>WIDTH or modulus[0]==0, SHALL not enter ITER.
- On the next edge: done=1, err=1, mm_out=0, busy=0.
- Return to IDLE.
REQ-016 ITER: exactly one radix-2 step per cycle, for i = 0..n-1.
- t = acc + num_1[i]*num_2
- acc = (t + t[0]*M) >> 1
REQ-017 The accumulator SHALL be WIDTH+2 bits wide so no intermediate value overflows.
REQ-018 After the iteration with i = n-1, go to FINAL.
REQ-019 FINAL, one cycle:
- mm_out = acc-M if acc>=M, else acc, truncated to WIDTH.
- Assert done=1, err=0, busy=0.
- Return to IDLE.
REQ-020 Latency, with start sampled at edge 0:
- Iterations occur on edges 1..n.
- mm_out and done are registered on edge n+1.
- busy is high from edge 0 up to edge n+1.
REQ-021 done and err SHALL be high for exactly one cycle per accepted start.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-023 start asserted in the same cycle done is high SHALL be accepted, because the FSM is in IDLE in that cycle.
REQ-024 Input port changes while busy SHALL not affect the result, because operands are latched.
REQ-025 Behaviour for inputs >= modulus is unspecified, except that the FSM SHALL still complete in n+1 cycles.

Reset
REQ-026 rst=1 at any edge, including mid-operation, SHALL force all of the following:
- state=IDLE, busy=0, done=0, err=0, mm_out=0.
- Accumulator and bit index cleared.
REQ-027 A start sampled at the same edge as rst=1 SHALL be discarded.
REQ-028 No state SHALL be reset asynchronously.

Structure
REQ-029 Package mont_pkg SHALL hold:
- the FSM state typedef (IDLE/ITER/FINAL);
- default WIDTH/LEN_W constants;
- the accumulator width constant ACC_W = WIDTH+2.
REQ-030 The combinational step of REQ-016 SHALL be a sub-module mont_step, parameterised by WIDTH; the top holds the FSM, registers and final subtraction.
REQ-031 The implementation SHALL use no clock gating and no derived or generated clocks.

Verification
REQ-032 WIDTH=32, M=13, n=4, num_1=5, num_2=7 -> mm_out=3, done on edge 5, err=0.
REQ-033 M=13, n=4, num_1=1, num_2=3 (R mod M) -> mm_out=1; then num_1=0, num_2=12 -> mm_out=0.
REQ-034 Rejected requests:
- modulus=12 -> done=1, err=1, mm_out=0 one edge after start.
- len=0 with M=13 -> same response.
- len=33 with WIDTH=32 -> same response.
REQ-035 Start and reset during an operation:
- start pulses during busy -> ignored, single done at the original time.
- rst at edge 2 of an n=8 run -> all outputs 0 on the next edge, no done.
- A fresh start after reset completes normally.
REQ-036 Random regression, 1000 cases:
- WIDTH=32, random odd M, n=32, operands < M.
- mm_out SHALL match a reference model of a*b*2^-32 mod M.
- Back-to-back starts issued on the done cycle.

Source files
------------

// File: rtl/mont_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mont_pkg : shared types and default sizes for the Montgomery multiplier
// rev 1.0
// ---------------------------------------------------------------------------
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LEN_W = 8;
  localparam int ACC_W     = DEF_WIDTH + 2;

endpackage
`default_nettype wire

// File: rtl/mont_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mont_step : one radix-2 Montgomery reduction step (combinational)
// rev 1.0
// ---------------------------------------------------------------------------
module mont_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] acc,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] acc_next
);

  // One spare bit above the accumulator keeps the sum exact before halving.
  logic [WIDTH+2:0] t;
  logic [WIDTH+2:0] u;

  always_comb begin
    t        = {1'b0, acc} + (a_bit ? {3'b000, b} : '0);
    u        = t + (t[0] ? {3'b000, m} : '0);
    acc_next = u[WIDTH+2:1];
  end

endmodule
`default_nettype wire

// File: rtl/mont_mult_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mont_mult_param : iterative Montgomery multiplier, num_1*num_2*2^-len mod M
// rev 1.0
// ---------------------------------------------------------------------------
module mont_mult_param
  import mont_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mm_out
);

  localparam int ACC_BITS = WIDTH + (mont_pkg::ACC_W - mont_pkg::DEF_WIDTH);

  state_t state, state_nxt;

  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_idx;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_mod;
  logic [ACC_BITS-1:0] r_acc;
  logic                r_rej;

  logic [ACC_BITS-1:0] w_step;
  logic [ACC_BITS-1:0] w_mod_ext;
  logic [ACC_BITS-1:0] w_final;
  logic                w_bad;
  logic                w_last;

  mont_step #(.WIDTH(WIDTH)) u_step (
    .acc      (r_acc),
    .a_bit    (r_a[0]),
    .b        (r_b),
    .m        (r_mod),
    .acc_next (w_step)
  );

  assign w_bad     = (len == '0) || (len > LEN_W'(WIDTH)) || !modulus[0];
  assign w_last    = (r_idx == r_len - LEN_W'(1));
  assign w_mod_ext = {{(ACC_BITS-WIDTH){1'b0}}, r_mod};
  assign w_final   = (r_acc >= w_mod_ext) ? (r_acc - w_mod_ext) : r_acc;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A rejected request passes through FINAL so err/done land one edge later.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = w_bad ? FINAL : ITER;
      ITER:    if (w_last) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_mod  <= '0;
      r_acc  <= '0;
      r_rej  <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      mm_out <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            r_len <= len;
            r_a   <= num_1;
            r_b   <= num_2;
            r_mod <= modulus;
            r_acc <= '0;
            r_idx <= '0;
            r_rej <= w_bad;
          end
        end
        ITER: begin
          r_acc <= w_step;
          r_a   <= r_a >> 1;
          r_idx <= r_idx + LEN_W'(1);
        end
        FINAL: begin
          done   <= 1'b1;
          err    <= r_rej;
          mm_out <= r_rej ? '0 : w_final[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mont_mult_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mont_mult_param : directed and random checks of mont_mult_param
// rev 1.0
// ---------------------------------------------------------------------------
module tb_mont_mult_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [31:0] num_1, num_2, modulus;
  logic        busy, done, err;
  logic [31:0] mm_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mont_mult_param #(.WIDTH(32), .LEN_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .num_1   (num_1),
    .num_2   (num_2),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .mm_out  (mm_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // a*b*(2^-n) mod m, using 2^-1 = (m+1)/2 for odd m
  function automatic logic [31:0] ref_mm(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] m, input int n);
    longint unsigned mm, inv2, r, p;
    mm   = 64'(m);
    inv2 = (mm + 1) / 2;
    r    = 1;
    for (int i = 0; i < n; i++) r = (r * inv2) % mm;
    p = (64'(a) * 64'(b)) % mm;
    return 32'((p * r) % mm);
  endfunction

  // Issue one request and wait for done; checks latency, result and pulse width.
  task automatic do_op(input string tag, input logic [7:0] l, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] m,
                       input logic exp_err, input logic [31:0] exp_out, input int exp_lat);
    int cyc;
    @(negedge clk);
    len = l; num_1 = a; num_2 = b; modulus = m; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_out"}, 64'(mm_out), 64'(exp_out));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int cyc, seen;
    logic [31:0] ca, cb, cm, ea;
    rst = 1'b1; start = 1'b0; len = '0; num_1 = '0; num_2 = '0; modulus = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err",  64'(err),  64'(0));
    chk("rst_out",  64'(mm_out), 64'(0));
    rst = 1'b0;

    do_op("ex_5x7",  8'd4, 32'd5, 32'd7,  32'd13, 1'b0, 32'd3, 5);
    do_op("ex_1x3",  8'd4, 32'd1, 32'd3,  32'd13, 1'b0, 32'd1, 5);
    do_op("ex_0x12", 8'd4, 32'd0, 32'd12, 32'd13, 1'b0, 32'd0, 5);
    do_op("rej_even", 8'd4,  32'd5, 32'd7, 32'd12, 1'b1, 32'd0, 1);
    do_op("ex_after", 8'd4,  32'd5, 32'd7, 32'd13, 1'b0, 32'd3, 5);
    do_op("rej_len0", 8'd0,  32'd5, 32'd7, 32'd13, 1'b1, 32'd0, 1);
    do_op("rej_len33", 8'd33, 32'd5, 32'd7, 32'd13, 1'b1, 32'd0, 1);
    do_op("len_full", 8'd32, 32'd123456, 32'd98765, 32'd1000003, 1'b0,
          ref_mm(32'd123456, 32'd98765, 32'd1000003, 32), 33);

    // start pulses and operand changes while busy must not disturb the run
    @(negedge clk);
    len = 8'd4; num_1 = 32'd5; num_2 = 32'd7; modulus = 32'd13; start = 1'b1;
    @(posedge clk);
    cyc = 0; seen = 0;
    while (cyc < 12) begin
      @(negedge clk);
      if (done) begin
        seen++;
        if (seen == 1) begin
          chk("ign_lat", 64'(cyc), 64'(5));
          chk("ign_out", 64'(mm_out), 64'(3));
        end
      end
      start = (cyc < 4);
      len = 8'd2; num_1 = 32'd9; num_2 = 32'd11; modulus = 32'd17;
      @(posedge clk); cyc++;
    end
    chk("ign_single_done", 64'(seen), 64'(1));
    start = 1'b0;

    // reset sampled at edge 2 of an n=8 run
    @(negedge clk);
    len = 8'd8; num_1 = 32'd5; num_2 = 32'd7; modulus = 32'd13; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_err",  64'(err),  64'(0));
    chk("mid_rst_out",  64'(mm_out), 64'(0));
    seen = 0;
    repeat (12) begin @(negedge clk); if (done) seen++; end
    chk("mid_rst_no_done", 64'(seen), 64'(0));

    // start coincident with reset is discarded
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'(0));

    do_op("post_rst", 8'd8, 32'd5, 32'd7, 32'd13, 1'b0, ref_mm(32'd5, 32'd7, 32'd13, 8), 9);

    // random back-to-back regression, each new start on the done cycle
    @(negedge clk);
    cm = $urandom | 32'd1; if (cm == 32'd1) cm = 32'd3;
    ca = $urandom % cm; cb = $urandom % cm;
    len = 8'd32; num_1 = ca; num_2 = cb; modulus = cm; start = 1'b1;
    ea = ref_mm(ca, cb, cm, 32);
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      num_1 = $urandom; num_2 = $urandom; modulus = $urandom;
      cyc = 0;
      while (!done && cyc < 100) begin
        @(posedge clk); cyc++;
        @(negedge clk);
      end
      chk("rnd_lat", 64'(cyc), 64'(33));
      chk("rnd_out", 64'(mm_out), 64'(ea));
      if (k < 999) begin
        cm = $urandom | 32'd1; if (cm == 32'd1) cm = 32'd3;
        ca = $urandom % cm; cb = $urandom % cm;
        len = 8'd32; num_1 = ca; num_2 = cb; modulus = cm; start = 1'b1;
        ea = ref_mm(ca, cb, cm, 32);
      end
    end
    @(negedge clk);
    chk("rnd_idle", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
